// File: rtl/bster_h.sv
// Host command opcode encodings shared by the host block and its users.
package bster_h;

  localparam logic [7:0] OP_INSERT_TOKEN = 8'h01;
  localparam logic [7:0] OP_REMOVE_TOKEN = 8'h02;
  localparam logic [7:0] OP_QUERY_TOKEN  = 8'h03;

endpackage

// File: rtl/bster_host_pkg.sv
// Shared FSM states, stream field layout constants and the timeout status code.
package bster_host_pkg;

  typedef logic [1:0] bster_state_t;

  localparam bster_state_t ST_IDLE     = 2'd0;
  localparam bster_state_t ST_SEND     = 2'd1;
  localparam bster_state_t ST_WAIT_CPL = 2'd2;
  localparam bster_state_t ST_RESP     = 2'd3;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned STATUS_W  = 8;
  localparam int unsigned TOKEN_LSB = 0;

  localparam logic [STATUS_W-1:0] TIMEOUT_STATUS = 8'hFF;

endpackage

// File: rtl/bster_host_codec.sv
// Combinational packing of command beats and unpacking of completion beats.
module bster_host_codec
  import bster_host_pkg::*;
#(
  parameter int unsigned TOKEN_WIDTH   = 8,
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter int unsigned AXI4S_WIDTH   = 128
) (
  input  logic [OP_W-1:0]          op,
  input  logic [TOKEN_WIDTH-1:0]   token,
  input  logic [PAYLOAD_WIDTH-1:0] payload,
  output logic [AXI4S_WIDTH-1:0]   cmd_data_c,
  input  logic [AXI4S_WIDTH-1:0]   cpl_data,
  output logic [STATUS_W-1:0]      cpl_status_c,
  output logic [TOKEN_WIDTH-1:0]   cpl_token_c,
  output logic [PAYLOAD_WIDTH-1:0] cpl_payload_c
);

  localparam int unsigned PAYLOAD_LSB = TOKEN_LSB + TOKEN_WIDTH;

  // Token at the bottom, payload above it, opcode/status in the top byte, zero fill.
  always_comb begin
    cmd_data_c = '0;
    cmd_data_c[TOKEN_LSB +: TOKEN_WIDTH]     = token;
    cmd_data_c[PAYLOAD_LSB +: PAYLOAD_WIDTH] = payload;
    cmd_data_c[AXI4S_WIDTH-1 -: OP_W]        = op;
  end

  assign cpl_token_c   = cpl_data[TOKEN_LSB +: TOKEN_WIDTH];
  assign cpl_payload_c = cpl_data[PAYLOAD_LSB +: PAYLOAD_WIDTH];
  assign cpl_status_c  = cpl_data[AXI4S_WIDTH-1 -: STATUS_W];

  // Fill bits between payload and status carry no information.
  logic unused_cpl_bits;
  assign unused_cpl_bits = ^cpl_data;

endmodule

// File: rtl/bster_host.sv
// Single-outstanding command host: request -> stream command -> completion -> response.
// Optional completion watchdog enabled by defining BSTER_HOST_TIMEOUT_EN.
module bster_host
  import bster_host_pkg::*;
#(
  parameter int unsigned TOKEN_WIDTH    = 8,
  parameter int unsigned PAYLOAD_WIDTH  = 32,
  parameter int unsigned AXI4S_WIDTH    = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_op,
  input  logic [TOKEN_WIDTH-1:0]   req_token,
  input  logic [PAYLOAD_WIDTH-1:0] req_payload,
  output logic                     cmd_tvalid,
  input  logic                     cmd_tready,
  output logic [AXI4S_WIDTH-1:0]   cmd_tdata,
  input  logic                     cpl_tvalid,
  output logic                     cpl_tready,
  input  logic [AXI4S_WIDTH-1:0]   cpl_tdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_status,
  output logic [TOKEN_WIDTH-1:0]   rsp_token,
  output logic [PAYLOAD_WIDTH-1:0] rsp_payload,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [31:0]              issued_cnt,
  output logic [31:0]              completed_cnt,
  output logic [15:0]              stray_cnt
);

  bster_state_t state_q, state_d;

  logic [AXI4S_WIDTH-1:0]   cmd_data_c;
  logic [STATUS_W-1:0]      cpl_status_c;
  logic [TOKEN_WIDTH-1:0]   cpl_token_c;
  logic [PAYLOAD_WIDTH-1:0] cpl_payload_c;
  logic [TOKEN_WIDTH-1:0]   req_token_q;
  logic [PAYLOAD_WIDTH-1:0] req_payload_q;

  logic req_hs_c, cmd_hs_c, cpl_hs_c, rsp_hs_c, timeout_c;

  bster_host_codec #(
    .TOKEN_WIDTH  (TOKEN_WIDTH),
    .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
    .AXI4S_WIDTH  (AXI4S_WIDTH)
  ) u_codec (
    .op           (req_op),
    .token        (req_token),
    .payload      (req_payload),
    .cmd_data_c   (cmd_data_c),
    .cpl_data     (cpl_tdata),
    .cpl_status_c (cpl_status_c),
    .cpl_token_c  (cpl_token_c),
    .cpl_payload_c(cpl_payload_c)
  );

  assign req_hs_c = req_valid  & req_ready;
  assign cmd_hs_c = cmd_tvalid & cmd_tready;
  assign cpl_hs_c = cpl_tvalid & cpl_tready;
  assign rsp_hs_c = rsp_valid  & rsp_ready;

`ifdef BSTER_HOST_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMR_W-1:0] wdog_q;

  // Counts cycles spent in WAIT_CPL; restarts on every entry.
  always_ff @(posedge aclk) begin
    if (rst || state_q != ST_WAIT_CPL) wdog_q <= '0;
    else                               wdog_q <= wdog_q + TMR_W'(1);
  end

  assign timeout_c = (state_q == ST_WAIT_CPL) && (wdog_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge aclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A completion in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req_hs_c)              state_d = ST_SEND;
      ST_SEND:     if (cmd_hs_c)              state_d = ST_WAIT_CPL;
      ST_WAIT_CPL: if (cpl_hs_c || timeout_c) state_d = ST_RESP;
      ST_RESP:     if (rsp_hs_c)              state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are valid from the first cycle of each state.
  always_ff @(posedge aclk) begin
    if (rst) begin
      req_ready     <= 1'b0;
      cpl_tready    <= 1'b0;
      cmd_tvalid    <= 1'b0;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      cmd_tdata     <= '0;
      req_token_q   <= '0;
      req_payload_q <= '0;
      rsp_status    <= '0;
      rsp_token     <= '0;
      rsp_payload   <= '0;
      rsp_timeout   <= 1'b0;
      issued_cnt    <= '0;
      completed_cnt <= '0;
      stray_cnt     <= '0;
    end else begin
      req_ready  <= (state_d == ST_IDLE);
      cpl_tready <= (state_d == ST_IDLE) || (state_d == ST_WAIT_CPL);
      cmd_tvalid <= (state_d == ST_SEND);
      rsp_valid  <= (state_d == ST_RESP);
      busy       <= (state_d != ST_IDLE);

      if (req_hs_c) begin
        cmd_tdata     <= cmd_data_c;
        req_token_q   <= req_token;
        req_payload_q <= req_payload;
      end

      if (cmd_hs_c) issued_cnt <= issued_cnt + 32'd1;

      if (cpl_hs_c && state_q == ST_IDLE) stray_cnt <= stray_cnt + 16'd1;

      if (cpl_hs_c && state_q == ST_WAIT_CPL) begin
        completed_cnt <= completed_cnt + 32'd1;
        rsp_status    <= cpl_status_c;
        rsp_token     <= cpl_token_c;
        rsp_payload   <= cpl_payload_c;
        rsp_timeout   <= 1'b0;
      end else if (timeout_c) begin
        rsp_status    <= TIMEOUT_STATUS;
        rsp_token     <= req_token_q;
        rsp_payload   <= req_payload_q;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bster_host.sv
// Directed bench for bster_host; the timeout scenario depends on BSTER_HOST_TIMEOUT_EN.
module tb_bster_host;
  import bster_h::*;

  localparam int unsigned TW = 8;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 128;

  logic          aclk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [7:0]    req_op;
  logic [TW-1:0] req_token;
  logic [PW-1:0] req_payload;
  logic          cmd_tvalid, cmd_tready;
  logic [AW-1:0] cmd_tdata;
  logic          cpl_tvalid, cpl_tready;
  logic [AW-1:0] cpl_tdata;
  logic          rsp_valid, rsp_ready;
  logic [7:0]    rsp_status;
  logic [TW-1:0] rsp_token;
  logic [PW-1:0] rsp_payload;
  logic          rsp_timeout, busy;
  logic [31:0]   issued_cnt, completed_cnt;
  logic [15:0]   stray_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  bster_host #(
    .TOKEN_WIDTH(TW), .PAYLOAD_WIDTH(PW), .AXI4S_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_token(req_token), .req_payload(req_payload),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
    .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready), .cpl_tdata(cpl_tdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_token(rsp_token), .rsp_payload(rsp_payload), .rsp_timeout(rsp_timeout),
    .busy(busy), .issued_cnt(issued_cnt), .completed_cnt(completed_cnt),
    .stray_cnt(stray_cnt)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if ({req_ready, cpl_tready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {req_ready, cpl_tready}); end
    n_vec++; if ({cmd_tvalid, rsp_valid, busy, rsp_timeout} !== 4'b0000) begin n_err++; $display("FAIL reset_valids: got %b want 0000", {cmd_tvalid, rsp_valid, busy, rsp_timeout}); end
    n_vec++; if ({issued_cnt, completed_cnt, stray_cnt} !== 80'd0) begin n_err++; $display("FAIL reset_counters: got %h want 0", {issued_cnt, completed_cnt, stray_cnt}); end
    n_vec++; if (cmd_tdata !== 128'd0) begin n_err++; $display("FAIL reset_cmd_tdata: got %h want 0", cmd_tdata); end
    rst = 1'b0;
    tick();
    n_vec++; if ({req_ready, cpl_tready} !== 2'b11) begin n_err++; $display("FAIL release_ready: got %b want 11", {req_ready, cpl_tready}); end
  endtask

  // Request handshake followed one cycle later by the packed command beat.
  task automatic test_request();
    req_valid = 1'b1; req_op = OP_INSERT_TOKEN; req_token = 8'd12; req_payload = 32'd24;
    tick();
    req_valid = 1'b0;
    n_vec++; if (cmd_tvalid !== 1'b1) begin n_err++; $display("FAIL req_cmd_tvalid: got %b want 1", cmd_tvalid); end
    n_vec++; if (cmd_tdata !== 128'h0100_0000_0000_0000_0000_0000_0000_180C) begin n_err++; $display("FAIL req_cmd_tdata: got %h want 0100..180c", cmd_tdata); end
    n_vec++; if ({req_ready, busy} !== 2'b01) begin n_err++; $display("FAIL req_ready_busy: got %b want 01", {req_ready, busy}); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({cmd_tvalid, req_ready, cmd_tdata} !== {1'b1, 1'b0, 128'h0100_0000_0000_0000_0000_0000_0000_180C}) begin
        n_err++; $display("FAIL cmd_stall[%0d]: got v=%b rdy=%b d=%h want v=1 rdy=0 stable", i, cmd_tvalid, req_ready, cmd_tdata);
      end
    end
    cmd_tready = 1'b1;
    tick();
    cmd_tready = 1'b0;
    n_vec++; if ({cmd_tvalid, cpl_tready} !== 2'b01) begin n_err++; $display("FAIL cmd_accept: got %b want 01", {cmd_tvalid, cpl_tready}); end
    n_vec++; if (issued_cnt !== 32'd1) begin n_err++; $display("FAIL issued_1: got %0d want 1", issued_cnt); end
  endtask

  task automatic test_completion();
    rsp_ready = 1'b0;
    cpl_tvalid = 1'b1; cpl_tdata = 128'h0000_0000_0000_0000_0000_0000_0000_180C;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if ({rsp_valid, rsp_timeout, cpl_tready, req_ready} !== 4'b1000) begin n_err++; $display("FAIL cpl_rsp_flags: got %b want 1000", {rsp_valid, rsp_timeout, cpl_tready, req_ready}); end
    n_vec++; if (completed_cnt !== 32'd1) begin n_err++; $display("FAIL completed_1: got %0d want 1", completed_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({rsp_valid, rsp_status, rsp_token, rsp_payload} !== {1'b1, 8'h00, 8'd12, 32'd24}) begin
        n_err++; $display("FAIL rsp_stall[%0d]: got v=%b s=%h t=%h p=%h want v=1 s=00 t=0c p=18", i, rsp_valid, rsp_status, rsp_token, rsp_payload);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin n_err++; $display("FAIL rsp_accept: got %b want 001", {rsp_valid, busy, req_ready}); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = OP_REMOVE_TOKEN; req_token = 8'hA5; req_payload = 32'hDEADBEEF;
    cmd_tready = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    n_vec++; if ({cmd_tvalid, cmd_tdata} !== {1'b1, 128'h0200_0000_0000_0000_0000_00DE_ADBE_EFA5}) begin n_err++; $display("FAIL b2b_cmd: got v=%b d=%h want v=1 d=0200..deadbeefa5", cmd_tvalid, cmd_tdata); end
    tick();
    cmd_tready = 1'b0;
    n_vec++; if ({cmd_tvalid, issued_cnt} !== {1'b0, 32'd2}) begin n_err++; $display("FAIL b2b_issued: got v=%b n=%0d want v=0 n=2", cmd_tvalid, issued_cnt); end
    cpl_tvalid = 1'b1; cpl_tdata = 128'h5A00_0000_0000_0000_0000_0012_3456_783C;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if ({rsp_valid, rsp_status, rsp_token, rsp_payload} !== {1'b1, 8'h5A, 8'h3C, 32'h12345678}) begin n_err++; $display("FAIL b2b_rsp: got v=%b s=%h t=%h p=%h want v=1 s=5a t=3c p=12345678", rsp_valid, rsp_status, rsp_token, rsp_payload); end
    tick();
    rsp_ready = 1'b0;
    n_vec++; if ({rsp_valid, req_ready, completed_cnt} !== {1'b0, 1'b1, 32'd2}) begin n_err++; $display("FAIL b2b_done: got v=%b rdy=%b n=%0d want v=0 rdy=1 n=2", rsp_valid, req_ready, completed_cnt); end
  endtask

  task automatic test_stray();
    cpl_tvalid = 1'b1; cpl_tdata = 128'h7700_0000_0000_0000_0000_0000_0000_0001;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if (stray_cnt !== 16'd1) begin n_err++; $display("FAIL stray_1: got %0d want 1", stray_cnt); end
    n_vec++; if ({rsp_valid, busy, completed_cnt} !== {2'b00, 32'd2}) begin n_err++; $display("FAIL stray_no_rsp: got v=%b busy=%b n=%0d want 0 0 2", rsp_valid, busy, completed_cnt); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stray_late_rsp: got %b want 0", rsp_valid); end
  endtask

  task automatic start_and_wait(input logic [TW-1:0] tok, input logic [PW-1:0] pay);
    req_valid = 1'b1; req_op = OP_QUERY_TOKEN; req_token = tok; req_payload = pay;
    cmd_tready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    cmd_tready = 1'b0;
  endtask

`ifdef BSTER_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    start_and_wait(8'h77, 32'h0BADF00D);
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_vec++; if (waited !== 16) begin n_err++; $display("FAIL timeout_latency: got %0d cycles want 16", waited); end
    n_vec++; if ({rsp_valid, rsp_timeout, rsp_status, rsp_token, rsp_payload} !== {2'b11, 8'hFF, 8'h77, 32'h0BADF00D}) begin n_err++; $display("FAIL timeout_rsp: got v=%b to=%b s=%h t=%h p=%h want 1 1 ff 77 0badf00d", rsp_valid, rsp_timeout, rsp_status, rsp_token, rsp_payload); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cpl_tvalid = 1'b1; cpl_tdata = 128'h0000_0000_0000_0000_0000_000B_ADF0_0D77;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if ({stray_cnt, rsp_valid, completed_cnt} !== {16'd2, 1'b0, 32'd2}) begin n_err++; $display("FAIL late_cpl_stray: got s=%0d v=%b c=%0d want 2 0 2", stray_cnt, rsp_valid, completed_cnt); end
    // Completion lands exactly in the expiry cycle.
    start_and_wait(8'h11, 32'h22);
    repeat (15) tick();
    cpl_tvalid = 1'b1; cpl_tdata = 128'h3300_0000_0000_0000_0000_0000_0000_2211;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if ({rsp_valid, rsp_timeout, rsp_status, completed_cnt} !== {2'b10, 8'h33, 32'd3}) begin n_err++; $display("FAIL expiry_race: got v=%b to=%b s=%h c=%0d want 1 0 33 3", rsp_valid, rsp_timeout, rsp_status, completed_cnt); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`else
  task automatic test_timeout();
    logic seen;
    start_and_wait(8'h77, 32'h0BADF00D);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++; if ({seen, busy} !== 2'b01) begin n_err++; $display("FAIL no_watchdog_wait: got seen=%b busy=%b want 0 1", seen, busy); end
    cpl_tvalid = 1'b1; cpl_tdata = 128'h4400_0000_0000_0000_0000_000B_ADF0_0D77;
    tick();
    cpl_tvalid = 1'b0;
    n_vec++; if ({rsp_valid, rsp_timeout, rsp_status, rsp_token, completed_cnt} !== {2'b10, 8'h44, 8'h77, 32'd3}) begin n_err++; $display("FAIL no_watchdog_rsp: got v=%b to=%b s=%h t=%h c=%0d want 1 0 44 77 3", rsp_valid, rsp_timeout, rsp_status, rsp_token, completed_cnt); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_in_wait();
    start_and_wait(8'h5C, 32'hCAFE0001);
    tick();
    n_vec++; if ({busy, cpl_tready, rsp_valid} !== 3'b110) begin n_err++; $display("FAIL pre_reset_wait: got %b want 110", {busy, cpl_tready, rsp_valid}); end
    rst = 1'b1;
    tick();
    n_vec++; if ({issued_cnt, completed_cnt, stray_cnt} !== 80'd0) begin n_err++; $display("FAIL wait_reset_counters: got %h want 0", {issued_cnt, completed_cnt, stray_cnt}); end
    n_vec++; if ({rsp_valid, busy, req_ready} !== 3'b000) begin n_err++; $display("FAIL wait_reset_outputs: got %b want 000", {rsp_valid, busy, req_ready}); end
    rst = 1'b0;
    tick();
    n_vec++; if ({req_ready, cpl_tready, rsp_valid} !== 3'b110) begin n_err++; $display("FAIL wait_release: got %b want 110", {req_ready, cpl_tready, rsp_valid}); end
    tick();
    n_vec++; if ({rsp_valid, cmd_tvalid} !== 2'b00) begin n_err++; $display("FAIL abandoned_cmd: got %b want 00", {rsp_valid, cmd_tvalid}); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_token = '0; req_payload = '0;
    cmd_tready = 1'b0; cpl_tvalid = 1'b0; cpl_tdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_request();
    test_backpressure();
    test_completion();
    test_back_to_back();
    test_stray();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bster_host.md
BSTER_HOST -- requirements
Module: bster_host

Interface
REQ-001 SHALL have parameters: TOKEN_WIDTH, default 8, token field width; PAYLOAD_WIDTH, default 32, payload field width; AXI4S_WIDTH, default 128, stream data width; TIMEOUT_CYCLES, default 1024, completion watchdog limit.
REQ-002 SHALL have ports (name, direction, width, meaning):
- aclk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_op  in  8  opcode (bster_h.sv encodings).
- req_token  in  TOKEN_WIDTH  token.
- req_payload  in  PAYLOAD_WIDTH  payload.
- cmd_tvalid  out  1  AXI4-stream command valid.
- cmd_tready  in  1  command ready.
- cmd_tdata  out  AXI4S_WIDTH  command beat.
- cpl_tvalid  in  1  completion valid.
- cpl_tready  out  1  completion ready.
- cpl_tdata  in  AXI4S_WIDTH  completion beat.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_status  out  8  completion status, or 8'hFF on timeout.
- rsp_token  out  TOKEN_WIDTH  returned token.
- rsp_payload  out  PAYLOAD_WIDTH  returned payload.
- rsp_timeout  out  1  response produced by the watchdog.
- busy  out  1  FSM not in IDLE.
- issued_cnt  out  32  commands accepted by the core.
- completed_cnt  out  32  completions accepted.
- stray_cnt  out  16  completions dropped.

Function
REQ-003 SHALL pack commands as: cmd_tdata[TOKEN_WIDTH-1:0]=token; next PAYLOAD_WIDTH bits=payload; [AXI4S_WIDTH-1 -: 8]=opcode; all other bits 0.
REQ-004 SHALL unpack completions with the same field layout, with status in the top byte.
REQ-005 SHALL implement the FSM IDLE -> SEND -> WAIT_CPL -> RESP -> IDLE, with exactly one command outstanding.
REQ-006 IDLE: req_ready=1 and cpl_tready=1; a request handshake in cycle N latches op, token and payload, moves to SEND, and drives cmd_tvalid=1 in cycle N+1.
REQ-007 SEND: cmd_tvalid=1 with cmd_tdata stable until cmd_tready; on the handshake, move to WAIT_CPL and increment issued_cnt.
REQ-008 WAIT_CPL: cpl_tready=1; a completion handshake in cycle M captures status, token and payload, increments completed_cnt, and drives rsp_valid=1 in cycle M+1 (RESP).
REQ-009 RESP: rsp_valid and rsp_* held stable until rsp_ready, then IDLE; req_ready=0 and cpl_tready=0 in RESP, so back-to-back requests cost one idle cycle.
REQ-010 A completion accepted in IDLE SHALL be dropped and increment stray_cnt.
REQ-011 Every counter SHALL wrap modulo 2^width.
REQ-012 cmd_tvalid SHALL never depend combinationally on cmd_tready; rsp_valid SHALL never depend combinationally on rsp_ready.

Reset
REQ-013 On rst, all outputs SHALL be 0 except the following: req_ready=0 and cpl_tready=0 during rst, and both =1 in the first cycle after release.
REQ-014 On rst, the FSM SHALL go to IDLE, all counters SHALL clear, and any in-flight command SHALL be abandoned with no response emitted.

Configuration
REQ-015 With BSTER_HOST_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WAIT_CPL; on reaching TIMEOUT_CYCLES-1 without a completion, the block enters RESP with rsp_timeout=1, rsp_status=8'hFF, and rsp_token/rsp_payload equal to the request values.
REQ-016 With BSTER_HOST_TIMEOUT_EN defined, a completion arriving in the expiry cycle SHALL win over the timeout; a completion arriving after a timeout counts as stray.
REQ-017 Without BSTER_HOST_TIMEOUT_EN, no timer SHALL be instantiated, rsp_timeout SHALL be tied 0, and WAIT_CPL waits indefinitely.

Structure
REQ-018 Package bster_host_pkg SHALL hold the FSM state enum, the field offset/width constants and TIMEOUT_STATUS=8'hFF; opcodes remain in bster_h.sv.
REQ-019 Sub-module bster_host_codec SHALL hold the combinational pack/unpack logic; the FSM, counters and watchdog live in bster_host.

Verification
REQ-020 Request INSERT_TOKEN, token 12, payload 24 -> cmd_tdata token field=12, payload field=24, top byte=INSERT_TOKEN, one cycle after the request handshake; issued_cnt=1.
REQ-021 cmd_tready held 0 for 5 cycles -> cmd_tvalid stays 1 and cmd_tdata stays unchanged; req_ready=0 throughout.
REQ-022 Completion status 0, token 12, payload 24, with rsp_ready=0 for 3 cycles -> rsp_* stable, then accepted; completed_cnt=1 and FSM back in IDLE.
REQ-023 Completion injected while IDLE -> stray_cnt=1, no rsp_valid.
REQ-024 With BSTER_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, no completion -> rsp_valid with rsp_timeout=1 and status 8'hFF; a later completion increments stray_cnt.
REQ-025 rst asserted in WAIT_CPL -> all counters 0, rsp_valid=0, and req_ready=1 in the cycle after release.
